// File: rtl/mem_arbiter_if.sv
// Bundle of the requester, memory and status signals around mem_arbiter.
// slave: the arbiter's view (it serves the requesters and drives memory).
// master: the environment's view (requesters plus memory model).
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned MASK_W = 8
);
   logic              ifu_req_valid;
   logic              ifu_req_ready;
   logic [ADDR_W-1:0] ifu_addr;
   logic              ifu_resp_valid;
   logic              ifu_resp_err;
   logic [DATA_W-1:0] ifu_rdata;

   logic              lsu_req_valid;
   logic              lsu_req_ready;
   logic [ADDR_W-1:0] lsu_addr;
   logic              lsu_wen;
   logic [DATA_W-1:0] lsu_wdata;
   logic [MASK_W-1:0] lsu_wmask;
   logic              lsu_resp_valid;
   logic              lsu_resp_err;
   logic [DATA_W-1:0] lsu_rdata;

   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wen;
   logic [DATA_W-1:0] mem_wdata;
   logic [MASK_W-1:0] mem_wmask;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport slave (
      input  ifu_req_valid, ifu_addr,
      input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      input  mem_req_ready, mem_resp_valid, mem_rdata,
      output ifu_req_ready, ifu_resp_valid, ifu_resp_err, ifu_rdata,
      output lsu_req_ready, lsu_resp_valid, lsu_resp_err, lsu_rdata,
      output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      output busy
   );

   modport master (
      output ifu_req_valid, ifu_addr,
      output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      output mem_req_ready, mem_resp_valid, mem_rdata,
      input  ifu_req_ready, ifu_resp_valid, ifu_resp_err, ifu_rdata,
      input  lsu_req_ready, lsu_resp_valid, lsu_resp_err, lsu_rdata,
      input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      input  busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU (read-only) and
// LSU (read/write). One transaction in flight; request fields are captured
// at acceptance; a watchdog turns a silent memory into an error response.
module mem_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MASK_W   = 8,
   parameter int unsigned MAX_WAIT = 255
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   // Counter only has to reach MAX_WAIT-1 (last WAIT cycle).
   localparam int unsigned     CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;   // 1 = LSU owns the transaction
   logic              last_q, last_d;     // 1 = LSU won the last grant
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wen_q, wen_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [MASK_W-1:0] wmask_q, wmask_d;

   logic ifu_win, lsu_win, resp_hit, timeout;

   // Arbitration, request capture and transaction sequencing.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wen_d    = wen_q;
      wdata_d  = wdata_q;
      wmask_d  = wmask_q;
      ifu_win  = 1'b0;
      lsu_win  = 1'b0;
      resp_hit = 1'b0;
      timeout  = 1'b0;
      unique case (state_q)
         StIdle: begin
            // On a tie the requester that did not win last time goes first.
            lsu_win = bus.lsu_req_valid & (~bus.ifu_req_valid | ~last_q);
            ifu_win = bus.ifu_req_valid & ~lsu_win;
            if (lsu_win) begin
               addr_d  = bus.lsu_addr;
               wen_d   = bus.lsu_wen;
               wdata_d = bus.lsu_wdata;
               wmask_d = bus.lsu_wmask;
               owner_d = 1'b1;
               last_d  = 1'b1;
               state_d = StReq;
            end else if (ifu_win) begin
               addr_d  = bus.ifu_addr;
               wen_d   = 1'b0;
               wdata_d = '0;
               wmask_d = '0;
               owner_d = 1'b0;
               last_d  = 1'b0;
               state_d = StReq;
            end
         end
         StReq: begin
            if (bus.mem_req_ready) begin
               if (bus.mem_resp_valid) begin
                  resp_hit = 1'b1;
                  state_d  = StIdle;
               end else begin
                  cnt_d   = '0;
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q + 1'b1;
            if (bus.mem_resp_valid) begin
               resp_hit = 1'b1;
               state_d  = StIdle;
            end else if (cnt_q == LAST_CNT) begin
               timeout = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and captured request registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         owner_q <= 1'b0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
      end
   end

   // Readies are gated by rst because IDLE is also the reset state.
   assign bus.ifu_req_ready  = ifu_win & ~rst;
   assign bus.lsu_req_ready  = lsu_win & ~rst;

   assign bus.mem_req_valid  = (state_q == StReq);
   assign bus.mem_addr       = addr_q;
   assign bus.mem_wen        = wen_q;
   assign bus.mem_wdata      = wdata_q;
   assign bus.mem_wmask      = wmask_q;

   assign bus.ifu_resp_valid = (resp_hit | timeout) & ~owner_q;
   assign bus.ifu_resp_err   = timeout & ~owner_q;
   assign bus.ifu_rdata      = (resp_hit & ~owner_q) ? bus.mem_rdata : '0;
   assign bus.lsu_resp_valid = (resp_hit | timeout) & owner_q;
   assign bus.lsu_resp_err   = timeout & owner_q;
   assign bus.lsu_rdata      = (resp_hit & owner_q) ? bus.mem_rdata : '0;

   assign bus.busy           = (state_q != StIdle);
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// transaction stream checked against a transaction-level expectation.
module tb_mem_arbiter;
   localparam int unsigned MW = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   bit   last_lsu = 1'b0;   // model: did the LSU win the most recent grant

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .MASK_W(8)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(8), .MAX_WAIT(MW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [33:0] ifu_resp();
      return {bus.ifu_resp_valid, bus.ifu_resp_err, bus.ifu_rdata};
   endfunction

   function automatic logic [33:0] lsu_resp();
      return {bus.lsu_resp_valid, bus.lsu_resp_err, bus.lsu_rdata};
   endfunction

   function automatic logic [72:0] mem_fields();
      return {bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.ifu_req_valid  = 1'b0;
      bus.ifu_addr       = '0;
      bus.lsu_req_valid  = 1'b0;
      bus.lsu_addr       = '0;
      bus.lsu_wen        = 1'b0;
      bus.lsu_wdata      = '0;
      bus.lsu_wmask      = '0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_rdata      = '0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      last_lsu = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.ifu_req_valid  = 1'b1;
      bus.lsu_req_valid  = 1'b1;
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 32'h1234_5678;
      @(negedge clk);
      checks++;
      if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b00) begin
         failures++;
         $display("FAIL rst_ready: got %b expected 00", {bus.ifu_req_ready, bus.lsu_req_ready});
      end
      checks++;
      if ({bus.busy, bus.mem_req_valid} !== 2'b00) begin
         failures++;
         $display("FAIL rst_busy_req: got %b expected 00", {bus.busy, bus.mem_req_valid});
      end
      checks++;
      if (mem_fields() !== 73'h0) begin
         failures++;
         $display("FAIL rst_fields: got %h expected 0", mem_fields());
      end
      checks++;
      if ({ifu_resp(), lsu_resp()} !== 68'h0) begin
         failures++;
         $display("FAIL rst_resp: got %h expected 0", {ifu_resp(), lsu_resp()});
      end
      clear_inputs();
      cyc();
      rst = 1'b0;
      last_lsu = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_idle_after: got %b expected 0", bus.busy);
      end
      cyc();
   endtask

   task automatic test_ifu_single();
      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr      = 32'h8000_0000;
      @(negedge clk);
      checks++;
      if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
         failures++;
         $display("FAIL ifu_c0_ready: got %b expected 10", {bus.ifu_req_ready, bus.lsu_req_ready});
      end
      cyc();
      last_lsu = 1'b0;
      bus.ifu_req_valid = 1'b0;
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.mem_req_valid !== 1'b1) begin
         failures++;
         $display("FAIL ifu_c1_req_valid: got %b expected 1", bus.mem_req_valid);
      end
      checks++;
      if (mem_fields() !== {32'h8000_0000, 1'b0, 32'h0, 8'h0}) begin
         failures++;
         $display("FAIL ifu_c1_fields: got %h expected %h", mem_fields(),
                  {32'h8000_0000, 1'b0, 32'h0, 8'h0});
      end
      cyc();
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 32'h0010_0093;
      @(negedge clk);
      checks++;
      if (ifu_resp() !== {2'b10, 32'h0010_0093}) begin
         failures++;
         $display("FAIL ifu_c2_resp: got %h expected %h", ifu_resp(), {2'b10, 32'h0010_0093});
      end
      checks++;
      if (lsu_resp() !== 34'h0) begin
         failures++;
         $display("FAIL ifu_c2_lsu_quiet: got %h expected 0", lsu_resp());
      end
      cyc();
      clear_inputs();
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL ifu_c3_idle: got %b expected 0", bus.busy);
      end
      cyc();
   endtask

   task automatic test_tie();
      int          grants;
      logic        exp_l;
      logic [31:0] rd;
      logic [33:0] exp_r;
      apply_reset();
      bus.ifu_req_valid  = 1'b1;
      bus.lsu_req_valid  = 1'b1;
      bus.ifu_addr       = $urandom();
      bus.lsu_addr       = $urandom();
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b1;
      grants = 0;
      // 4 grants plus the final transaction's completion cycle.
      for (int c = 0; c < 20 && grants <= 4; c++) begin
         rd = $urandom();
         bus.mem_rdata = rd;
         if (grants == 4) begin
            bus.ifu_req_valid = 1'b0;
            bus.lsu_req_valid = 1'b0;
         end
         @(negedge clk);
         if (bus.ifu_req_ready || bus.lsu_req_ready) begin
            checks++;
            if (bus.ifu_req_ready && bus.lsu_req_ready) begin
               failures++;
               $display("FAIL tie_one_ready: got 11 expected one-hot");
            end
            exp_l = ~last_lsu;
            checks++;
            if (bus.lsu_req_ready !== exp_l) begin
               failures++;
               $display("FAIL tie_grant%0d: got lsu=%b expected lsu=%b", grants,
                        bus.lsu_req_ready, exp_l);
            end
            last_lsu = exp_l;
            grants++;
         end else begin
            exp_r = {2'b10, rd};
            checks++;
            if ({ifu_resp(), lsu_resp()} !== (last_lsu ? {34'h0, exp_r} : {exp_r, 34'h0})) begin
               failures++;
               $display("FAIL tie_resp: got %h expected %h", {ifu_resp(), lsu_resp()},
                        last_lsu ? {34'h0, exp_r} : {exp_r, 34'h0});
            end
            if (grants == 4) grants++;
         end
         cyc();
      end
      checks++;
      if (grants != 5) begin
         failures++;
         $display("FAIL tie_count: got %0d expected 4 grants plus completion", grants);
      end
      clear_inputs();
   endtask

   task automatic test_lsu_write_stall();
      logic [31:0] rd;
      bus.lsu_req_valid = 1'b1;
      bus.lsu_addr      = 32'h8000_0010;
      bus.lsu_wen       = 1'b1;
      bus.lsu_wdata     = 32'hDEAD_BEEF;
      bus.lsu_wmask     = 8'h0F;
      @(negedge clk);
      checks++;
      if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01) begin
         failures++;
         $display("FAIL wr_accept: got %b expected 01", {bus.ifu_req_ready, bus.lsu_req_ready});
      end
      cyc();
      last_lsu = 1'b1;
      for (int s = 0; s < 4; s++) begin
         // Requester fields wander after acceptance; memory side must not.
         bus.lsu_req_valid = 1'b0;
         bus.lsu_addr      = $urandom();
         bus.lsu_wdata     = $urandom();
         bus.lsu_wmask     = 8'($urandom());
         bus.mem_req_ready = (s == 3);
         @(negedge clk);
         checks++;
         if (bus.mem_req_valid !== 1'b1) begin
            failures++;
            $display("FAIL wr_req_valid%0d: got %b expected 1", s, bus.mem_req_valid);
         end
         checks++;
         if (mem_fields() !== {32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 8'h0F}) begin
            failures++;
            $display("FAIL wr_fields%0d: got %h expected %h", s, mem_fields(),
                     {32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 8'h0F});
         end
         cyc();
      end
      rd = $urandom();
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = rd;
      @(negedge clk);
      checks++;
      if ({ifu_resp(), lsu_resp()} !== {34'h0, 2'b10, rd}) begin
         failures++;
         $display("FAIL wr_ack: got %h expected %h", {ifu_resp(), lsu_resp()}, {34'h0, 2'b10, rd});
      end
      cyc();
      clear_inputs();
   endtask

   task automatic test_timeout();
      logic [33:0] exp_r;
      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr      = $urandom();
      cyc();
      last_lsu = 1'b0;
      bus.ifu_req_valid = 1'b0;
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.mem_req_valid !== 1'b1) begin
         failures++;
         $display("FAIL to_req: got %b expected 1", bus.mem_req_valid);
      end
      cyc();
      bus.mem_req_ready = 1'b0;
      bus.mem_rdata     = 32'hFFFF_FFFF;
      for (int w = 1; w <= int'(MW); w++) begin
         @(negedge clk);
         checks++;
         if ({bus.busy, bus.mem_req_valid} !== 2'b10) begin
            failures++;
            $display("FAIL to_wait%0d: got busy,req=%b expected 10", w,
                     {bus.busy, bus.mem_req_valid});
         end
         exp_r = (w == int'(MW)) ? {2'b11, 32'h0} : 34'h0;
         checks++;
         if ({ifu_resp(), lsu_resp()} !== {exp_r, 34'h0}) begin
            failures++;
            $display("FAIL to_resp%0d: got %h expected %h", w, {ifu_resp(), lsu_resp()},
                     {exp_r, 34'h0});
         end
         cyc();
      end
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 32'h1234_5678;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL to_busy_fall: got %b expected 0", bus.busy);
      end
      checks++;
      if ({ifu_resp(), lsu_resp()} !== 68'h0) begin
         failures++;
         $display("FAIL to_late_ignored: got %h expected 0", {ifu_resp(), lsu_resp()});
      end
      cyc();
      clear_inputs();
   endtask

   task automatic test_same_cycle();
      logic [31:0] a, wd, rd;
      logic [7:0]  wm;
      a  = $urandom();
      wd = $urandom();
      wm = 8'($urandom());
      rd = $urandom();
      bus.lsu_req_valid = 1'b1;
      bus.lsu_addr      = a;
      bus.lsu_wen       = 1'b0;
      bus.lsu_wdata     = wd;
      bus.lsu_wmask     = wm;
      @(negedge clk);
      checks++;
      if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01) begin
         failures++;
         $display("FAIL sc_accept: got %b expected 01", {bus.ifu_req_ready, bus.lsu_req_ready});
      end
      cyc();
      last_lsu = 1'b1;
      bus.lsu_req_valid  = 1'b0;
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = rd;
      @(negedge clk);
      checks++;
      if ({ifu_resp(), lsu_resp()} !== {34'h0, 2'b10, rd}) begin
         failures++;
         $display("FAIL sc_resp: got %h expected %h", {ifu_resp(), lsu_resp()}, {34'h0, 2'b10, rd});
      end
      checks++;
      if (mem_fields() !== {a, 1'b0, wd, wm}) begin
         failures++;
         $display("FAIL sc_fields: got %h expected %h", mem_fields(), {a, 1'b0, wd, wm});
      end
      cyc();
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.ifu_req_valid  = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.ifu_req_ready} !== 2'b01) begin
         failures++;
         $display("FAIL sc_next_accept: got busy,ifu_ready=%b expected 01",
                  {bus.busy, bus.ifu_req_ready});
      end
      cyc();
      last_lsu = 1'b0;
      bus.ifu_req_valid  = 1'b0;
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b1;
      cyc();
      clear_inputs();
   endtask

   task automatic test_async_reset();
      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr      = $urandom();
      cyc();
      bus.ifu_req_valid = 1'b0;
      bus.mem_req_ready = 1'b1;
      cyc();
      // Now in WAIT with a response being presented.
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 32'hCAFE_F00D;
      #1;
      checks++;
      if ({bus.busy, ifu_resp()} !== {1'b1, 2'b10, 32'hCAFE_F00D}) begin
         failures++;
         $display("FAIL ar_pre: got %h expected %h", {bus.busy, ifu_resp()},
                  {1'b1, 2'b10, 32'hCAFE_F00D});
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.busy, bus.mem_req_valid} !== 2'b00) begin
         failures++;
         $display("FAIL ar_busy_req: got %b expected 00", {bus.busy, bus.mem_req_valid});
      end
      checks++;
      if ({ifu_resp(), lsu_resp()} !== 68'h0) begin
         failures++;
         $display("FAIL ar_resp: got %h expected 0", {ifu_resp(), lsu_resp()});
      end
      rst = 1'b0;
      last_lsu = 1'b0;
      clear_inputs();
      bus.ifu_req_valid = 1'b1;
      bus.lsu_req_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01) begin
         failures++;
         $display("FAIL ar_tie_lsu: got %b expected 01", {bus.ifu_req_ready, bus.lsu_req_ready});
      end
      cyc();
      last_lsu = 1'b1;
      bus.ifu_req_valid  = 1'b0;
      bus.lsu_req_valid  = 1'b0;
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b1;
      cyc();
      clear_inputs();
   endtask

   task automatic test_random();
      logic        iv, lv, we, exp_l;
      logic [31:0] ia, la, wd, rd;
      logic [7:0]  wm;
      logic [72:0] exp_f;
      logic [33:0] exp_r;
      int          gap, stall, delay;
      for (int t = 0; t < 60; t++) begin
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            bus.ifu_req_valid  = 1'b0;
            bus.lsu_req_valid  = 1'b0;
            bus.mem_resp_valid = 1'($urandom_range(0, 1));
            bus.mem_rdata      = $urandom();
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.ifu_req_ready, bus.lsu_req_ready, ifu_resp(), lsu_resp()} !== 71'h0)
            begin
               failures++;
               $display("FAIL rnd_idle t%0d: got %h expected 0", t,
                        {bus.busy, bus.ifu_req_ready, bus.lsu_req_ready, ifu_resp(), lsu_resp()});
            end
            cyc();
         end
         iv = 1'($urandom_range(0, 1));
         lv = 1'($urandom_range(0, 1));
         if (!iv && !lv) lv = 1'b1;
         ia = $urandom();
         la = $urandom();
         we = 1'($urandom_range(0, 1));
         wd = $urandom();
         wm = 8'($urandom());
         bus.ifu_req_valid  = iv;
         bus.ifu_addr       = ia;
         bus.lsu_req_valid  = lv;
         bus.lsu_addr       = la;
         bus.lsu_wen        = we;
         bus.lsu_wdata      = wd;
         bus.lsu_wmask      = wm;
         bus.mem_req_ready  = 1'($urandom_range(0, 1));
         bus.mem_resp_valid = 1'($urandom_range(0, 1));
         exp_l = lv && (!iv || !last_lsu);
         exp_f = exp_l ? {la, we, wd, wm} : {ia, 1'b0, 32'h0, 8'h0};
         @(negedge clk);
         checks++;
         if ({bus.ifu_req_ready, bus.lsu_req_ready} !== {~exp_l, exp_l}) begin
            failures++;
            $display("FAIL rnd_grant t%0d: got %b expected %b", t,
                     {bus.ifu_req_ready, bus.lsu_req_ready}, {~exp_l, exp_l});
         end
         cyc();
         last_lsu = exp_l;
         stall = $urandom_range(0, 2);
         delay = $urandom_range(0, MW + 1);  // MW+1: memory never answers
         for (int s = 0; s <= stall; s++) begin
            bus.ifu_req_valid  = 1'($urandom_range(0, 1));
            bus.lsu_req_valid  = 1'($urandom_range(0, 1));
            bus.ifu_addr       = $urandom();
            bus.lsu_addr       = $urandom();
            bus.lsu_wdata      = $urandom();
            bus.mem_req_ready  = (s == stall);
            bus.mem_resp_valid = (s == stall) && (delay == 0);
            rd = $urandom();
            bus.mem_rdata = rd;
            exp_r = ((s == stall) && (delay == 0)) ? {2'b10, rd} : 34'h0;
            @(negedge clk);
            checks++;
            if ({bus.mem_req_valid, bus.busy, bus.ifu_req_ready, bus.lsu_req_ready} !== 4'b1100 ||
                mem_fields() !== exp_f) begin
               failures++;
               $display("FAIL rnd_req t%0d: got %b/%h expected 1100/%h", t,
                        {bus.mem_req_valid, bus.busy, bus.ifu_req_ready, bus.lsu_req_ready},
                        mem_fields(), exp_f);
            end
            checks++;
            if ({ifu_resp(), lsu_resp()} !== (exp_l ? {34'h0, exp_r} : {exp_r, 34'h0})) begin
               failures++;
               $display("FAIL rnd_req_resp t%0d: got %h expected %h", t,
                        {ifu_resp(), lsu_resp()}, exp_l ? {34'h0, exp_r} : {exp_r, 34'h0});
            end
            cyc();
         end
         if (delay != 0) begin
            for (int w = 1; w <= int'(MW); w++) begin
               bus.ifu_req_valid  = 1'($urandom_range(0, 1));
               bus.lsu_req_valid  = 1'($urandom_range(0, 1));
               bus.mem_req_ready  = 1'($urandom_range(0, 1));
               bus.mem_resp_valid = (w == delay);
               rd = $urandom();
               bus.mem_rdata = rd;
               if (w == delay)                          exp_r = {2'b10, rd};
               else if (delay > int'(MW) && w == int'(MW)) exp_r = {2'b11, 32'h0};
               else                                     exp_r = 34'h0;
               @(negedge clk);
               checks++;
               if ({bus.mem_req_valid, bus.busy, bus.ifu_req_ready, bus.lsu_req_ready} !== 4'b0100)
               begin
                  failures++;
                  $display("FAIL rnd_wait t%0d w%0d: got %b expected 0100", t, w,
                           {bus.mem_req_valid, bus.busy, bus.ifu_req_ready, bus.lsu_req_ready});
               end
               checks++;
               if ({ifu_resp(), lsu_resp()} !== (exp_l ? {34'h0, exp_r} : {exp_r, 34'h0})) begin
                  failures++;
                  $display("FAIL rnd_wait_resp t%0d w%0d: got %h expected %h", t, w,
                           {ifu_resp(), lsu_resp()}, exp_l ? {34'h0, exp_r} : {exp_r, 34'h0});
               end
               cyc();
               if (exp_r[33]) break;
            end
         end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_ifu_single();
      test_tie();
      test_lsu_write_stall();
      test_timeout();
      test_same_cycle();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end
endmodule
